fft_mag_sq: RTL

- Stage directly downstream of the FFT prefetch FIFO in the spectrum-analyzer datapath.
- Pops complex FFT bins ({im, re}, 64-bit) from the FIFO's first-word-fall-through read side.
- Computes the power per bin, re^2 + im^2, in a 3-stage stall-able pipeline.
- Tags each result with its bin index and frame start/end markers for the display/averaging stage.

---
 rtl/spectrum_pkg.sv | 26 ++
 rtl/fft_sq_mult.sv | 38 +++
 rtl/fft_mag_sq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants and bin-tag type for the spectrum-analyzer datapath.
// Every stage from the FFT read side down to display/averaging imports
// this package, so bin widths and power widths stay consistent.
package spectrum_pkg;

  localparam int IQ_W   = 32;          // signed width of re and of im
  localparam int LEN_W  = 11;          // log2 of FFT length
  localparam int PWR_W  = 2*IQ_W + 1;  // re^2 + im^2 never overflows this
  localparam int FCNT_W = 16;          // completed-frame counter width

  typedef struct packed {
    logic [LEN_W-1:0] bin;
    logic             sof;
    logic             eof;
  } bin_tag_t;

  // Build the tag for a bin: sof on bin 0, eof on the last bin of a frame.
  function automatic bin_tag_t make_tag(input logic [LEN_W-1:0] bin);
    bin_tag_t t;
    t.bin = bin;
    t.sof = (bin == '0);
    t.eof = (&bin);
    return t;
  endfunction

endpackage

// File: rtl/fft_sq_mult.sv
// Signed squarer with a registered product and a clock enable.
// Kept as its own module so the synthesizer maps each instance onto
// dedicated multiplier resources.
//   clk - clock
//   ce  - load enable for the product register
//   a   - signed operand, W bits
//   p   - registered a*a, 2*W bits signed (always non-negative)
module fft_sq_mult
  import spectrum_pkg::*;
#(
  parameter int W = IQ_W
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic signed [W-1:0]   a,
  output logic signed [2*W-1:0] p
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] p_d;
  logic signed [2*W-1:0] p_q;

  // Sign-extend first so the full 2*W-bit product is formed;
  // (-2^(W-1))^2 = 2^(2W-2) still fits as a positive value.
  assign a_ext = $signed({{W{a[W-1]}}, a});

  always_comb begin
    p_d = p_q;
    if (ce) p_d = a_ext * a_ext;
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/fft_mag_sq.sv
// Power-per-bin stage behind the FFT prefetch FIFO.
// Pops complex bins {im, re} from a first-word-fall-through FIFO and emits
// re^2 + im^2 through a 3-stage pipeline that stalls as a whole, tagged
// with bin index and frame start/end markers.
//   clk, rst             - clock, asynchronous active-high reset
//   frame_clr            - synchronous flush; bin count restarts at 0
//   fifo_rd_vld/data/en  - FIFO read side (data = {im, re}), pop strobe
//   pwr_vld/rdy          - output valid/ready handshake
//   pwr_data             - unsigned re^2 + im^2
//   pwr_bin/sof/eof      - bin index and frame markers of pwr_data
//   frame_cnt            - frames whose eof word has been accepted
module fft_mag_sq
  import spectrum_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_clr,
  input  logic                fifo_rd_vld,
  input  logic [2*IQ_W-1:0]   fifo_rd_data,
  output logic                fifo_rd_en,
  output logic                pwr_vld,
  input  logic                pwr_rdy,
  output logic [PWR_W-1:0]    pwr_data,
  output logic [LEN_W-1:0]    pwr_bin,
  output logic                pwr_sof,
  output logic                pwr_eof,
  output logic [FCNT_W-1:0]   frame_cnt
);

  logic adv;
  logic pop;

  logic                     vld_p1_q, vld_p1_d;
  logic                     vld_p2_q, vld_p2_d;
  logic                     pwr_vld_q, pwr_vld_d;
  logic [LEN_W-1:0]         bin_cnt_q, bin_cnt_d;
  logic [FCNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic signed [IQ_W-1:0]   re_p1_q, re_p1_d;
  logic signed [IQ_W-1:0]   im_p1_q, im_p1_d;
  bin_tag_t                 tag_p1_q, tag_p1_d;
  bin_tag_t                 tag_p2_q, tag_p2_d;
  bin_tag_t                 tag_p3_q, tag_p3_d;
  logic signed [2*IQ_W-1:0] re_sq_p2;
  logic signed [2*IQ_W-1:0] im_sq_p2;
  logic [PWR_W-1:0]         pwr_p3_q, pwr_p3_d;

  // The output register is the only place that can refuse data, so the
  // whole pipeline advances whenever it is empty or being drained.
  assign adv = ~pwr_vld_q | pwr_rdy;
  // rst gating keeps the strobe low while the block is held in reset.
  assign pop = fifo_rd_vld & adv & ~frame_clr & ~rst;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    vld_p2_d    = vld_p2_q;
    pwr_vld_d   = pwr_vld_q;
    bin_cnt_d   = bin_cnt_q;
    frame_cnt_d = frame_cnt_q;
    re_p1_d     = re_p1_q;
    im_p1_d     = im_p1_q;
    tag_p1_d    = tag_p1_q;
    tag_p2_d    = tag_p2_q;
    tag_p3_d    = tag_p3_q;
    pwr_p3_d    = pwr_p3_q;

    if (adv) begin
      // S1: capture the popped word (a bubble when nothing was popped)
      vld_p1_d = pop;
      re_p1_d  = $signed(fifo_rd_data[IQ_W-1:0]);
      im_p1_d  = $signed(fifo_rd_data[2*IQ_W-1:IQ_W]);
      tag_p1_d = make_tag(bin_cnt_q);
      // S2: squares are registered inside the multipliers
      vld_p2_d = vld_p1_q;
      tag_p2_d = tag_p1_q;
      // S3: both squares are non-negative, so zero-extension is exact
      pwr_vld_d = vld_p2_q;
      tag_p3_d  = tag_p2_q;
      pwr_p3_d  = {1'b0, re_sq_p2} + {1'b0, im_sq_p2};
    end

    if (pop) bin_cnt_d = bin_cnt_q + LEN_W'(1);

    // A transfer in the same cycle as frame_clr still counts downstream.
    if (pwr_vld_q & pwr_rdy & tag_p3_q.eof) frame_cnt_d = frame_cnt_q + FCNT_W'(1);

    if (frame_clr) begin
      vld_p1_d  = 1'b0;
      vld_p2_d  = 1'b0;
      pwr_vld_d = 1'b0;
      bin_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      pwr_vld_q   <= 1'b0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      tag_p3_q    <= '0;
      pwr_p3_q    <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      pwr_vld_q   <= pwr_vld_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tag_p3_q    <= tag_p3_d;
      pwr_p3_q    <= pwr_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    re_p1_q  <= re_p1_d;
    im_p1_q  <= im_p1_d;
    tag_p1_q <= tag_p1_d;
    tag_p2_q <= tag_p2_d;
  end

  // S2 ---------------------------------------------------------------
  fft_sq_mult #(.W(IQ_W)) u_sq_re (
    .clk (clk),
    .ce  (adv),
    .a   (re_p1_q),
    .p   (re_sq_p2)
  );

  fft_sq_mult #(.W(IQ_W)) u_sq_im (
    .clk (clk),
    .ce  (adv),
    .a   (im_p1_q),
    .p   (im_sq_p2)
  );

  assign fifo_rd_en = pop;
  assign pwr_vld    = pwr_vld_q;
  assign pwr_data   = pwr_p3_q;
  assign pwr_bin    = tag_p3_q.bin;
  assign pwr_sof    = tag_p3_q.sof;
  assign pwr_eof    = tag_p3_q.eof;
  assign frame_cnt  = frame_cnt_q;

endmodule
